rs_sched: RTL and testbench
===========================

Name: rs_sched

Overview:
- Per-reservation-station scheduler that sits beside an array of NUM_ENTRIES rs_entry instances.
- Picks the allocation target for each dispatched uop and arbitrates issue among entries requesting in rs1, oldest first.
- Age is kept in an age matrix.
- Drives the per-entry alloc and grant strobes and presents a single issue select to the execute unit.

Parameters:
- NUM_ENTRIES, 8, number of RS entries managed (2..32).
- CNT_W, $clog2(NUM_ENTRIES+1), occupancy counter width (derived; do not override).

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- disp_valid_rs0  in  1  uop offered for allocation this cycle.
- disp_ready_rs0  out  1  a free entry exists; allocation happens when valid&ready.
- e_alloc_rs0  out  NUM_ENTRIES  one-hot alloc strobe to entries (zero if no allocation).
- e_valid  in  NUM_ENTRIES  per-entry valid from the entries.
- e_req_issue_rs1  in  NUM_ENTRIES  per-entry issue request.
- ex_ready_rs1  in  1  execute unit can accept an issue this cycle.
- e_gnt_issue_rs1  out  NUM_ENTRIES  one-hot grant; zero when nothing issues.
- iss_valid_rs1  out  1  an issue occurs this cycle.
- iss_idx_rs1  out  $clog2(NUM_ENTRIES)  index of granted entry; the mux select for the issue packet.
- occ_rs0  out  CNT_W  registered count of occupied entries.
- Under RS_SCHED_PERF_EN only: perf_issue_cnt out 32; perf_full_stall_cnt out 32.

Behaviour:
- Reset (reset_n low, asynchronous):
  - Age matrix and occ_rs0 clear to 0; perf counters clear to 0.
  - disp_ready_rs0, e_alloc_rs0, e_gnt_issue_rs1, iss_valid_rs1 and iss_idx_rs1 are forced to 0 while reset_n is low.
- Free vector = ~e_valid.
  - disp_ready_rs0 = |free.
  - The alloc target is the lowest-index free entry.
  - e_alloc_rs0 = target one-hot & {N{disp_valid_rs0 & disp_ready_rs0}}.
  - Combinational, zero-cycle latency; the entry becomes valid the next cycle.
- An entry granted in cycle t still shows e_valid in t, so it is never reallocated in t. It becomes free in t+1.
- Age matrix: age[i][j]=1 means entry i is older than j. On alloc of entry k at the clock edge:
  - row k is cleared;
  - column k is set to e_valid (every currently valid entry is older than k);
  - age[k][k] stays 0.
- Dealloc does not touch the matrix; stale bits are masked by the request vector.
- Issue select: cand = e_req_issue_rs1 & e_valid. Entry i wins if cand[i] and no j with cand[j] & age[j][i].
  - The result is exactly one-hot whenever cand≠0; assert this.
  - e_gnt_issue_rs1 = win & {N{ex_ready_rs1}}.
  - iss_valid_rs1 = |e_gnt_issue_rs1.
  - iss_idx_rs1 = encode(win), or 0 when there is no win.
  - Issue is combinational in rs1 with no added latency.
- ex_ready_rs1 low: no grant. Requests remain, and the same oldest entry wins again once ready returns (no starvation of the oldest).
- occ_rs0 next value = occ + alloc − grant.
  - Simultaneous alloc and grant leave it unchanged.
  - Assert occ never exceeds NUM_ENTRIES or underflows.
  - Assert occ_rs0 == popcount(e_valid) one cycle after any change settles.
- Full (all valid): disp_ready_rs0=0, and disp_valid is held by upstream. A grant in t gives ready in t+1.
- Reset mid-operation: all state is dropped immediately. Entries are reset by their own reset in the same cycle.

Optional Feature:
- RS_SCHED_PERF_EN defined:
  - perf_issue_cnt increments on iss_valid_rs1.
  - perf_full_stall_cnt increments on disp_valid_rs0 & ~disp_ready_rs0.
  - Both saturate at 2^32−1 and are cleared by reset.
- Undefined: both ports and counters are absent; function is otherwise identical.

Decomposition:
- common package: NUM_RS_ENTRIES constant and typedef t_rs_idx (logic[$clog2(NUM_RS_ENTRIES)-1:0]).
- Add to the package a function for the one-hot-to-index encode and a find-first-set helper.
- Sub-module rs_age_matrix: holds the NxN matrix, takes the alloc one-hot and the candidate vector, and returns the oldest one-hot.
- rs_sched keeps alloc selection, grant gating, the occupancy counter and the perf counters.

Test Plan:
- NUM_ENTRIES=4, empty; dispatch 4 uops back-to-back → e_alloc_rs0 = 0001, 0010, 0100, 1000 across 4 cycles. 5th cycle: disp_ready_rs0=0, occ_rs0=4.
- Alloc order 2,0,3 (pre-fill 1 then free it); all request with ex_ready=1 → grants 0100, 0001, 1000 in successive cycles.
- Full RS; grant entry 1 in cycle t with disp_valid held → disp_ready=1 in t+1, e_alloc=0010 in t+1, occ stays 4.
- ex_ready_rs1=0 for 3 cycles with entries 0 and 3 requesting (3 older) → no grant, iss_valid=0. On release, grant=1000 and iss_idx=3.
- Simultaneous alloc into entry 2 and grant of entry 0 → occ unchanged; new entry 2 is youngest, so entry 1 beats it.
- Assert reset_n low mid-stream (occ=3) → all outputs 0 asynchronously. After release: occ=0, disp_ready reflects ~e_valid. With RS_SCHED_PERF_EN, counters read 0.

Source files
------------

// File: rtl/rs_sched_pkg.sv
// rtl/rs_sched_pkg.sv - shared constants, index type and bit-vector helpers for the RS scheduler
package rs_sched_pkg;

  localparam int NUM_RS_ENTRIES = 8;
  // Widest vector the helpers accept; callers zero-extend narrower vectors.
  localparam int MAX_ENTRIES = 32;

  typedef logic [$clog2(NUM_RS_ENTRIES)-1:0] t_rs_idx;

  // Index of the set bit of a one-hot vector; 0 for an all-zero vector.
  function automatic logic [4:0] onehot_to_idx(input logic [MAX_ENTRIES-1:0] v);
    logic [4:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_ENTRIES; i++) begin
      if (v[i]) idx = idx | 5'(i);
    end
    return idx;
  endfunction

  // Lowest set bit of v returned as a one-hot vector (zero if v is zero).
  function automatic logic [MAX_ENTRIES-1:0] find_first_set(input logic [MAX_ENTRIES-1:0] v);
    return v & (~v + 32'd1);
  endfunction

endpackage

// File: rtl/rs_age_matrix.sv
// rtl/rs_age_matrix.sv - NxN age matrix picking the oldest candidate entry
module rs_age_matrix
  import rs_sched_pkg::*;
#(
  parameter int N = NUM_RS_ENTRIES
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [N-1:0] alloc_oh,
  input  logic [N-1:0] valid,
  input  logic [N-1:0] cand,
  output logic [N-1:0] oldest_oh
);

  // age[i][j] = 1 means entry i is older than entry j.
  logic [N-1:0] age [N];
  logic         blocked;

  // On alloc of k: row k cleared (k is younger than everyone), column k takes
  // the currently valid set (they are all older than k); diagonal stays 0.
  // Freed entries are left stale; the candidate mask hides them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N; i++) age[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          if (alloc_oh[i]) age[i][j] <= 1'b0;
          else if (alloc_oh[j]) age[i][j] <= valid[i] && (i != j);
        end
      end
    end
  end

  // A candidate wins when no other candidate is older than it.
  always_comb begin
    oldest_oh = '0;
    blocked   = 1'b0;
    for (int i = 0; i < N; i++) begin
      blocked = 1'b0;
      for (int j = 0; j < N; j++) begin
        if (cand[j] && age[j][i]) blocked = 1'b1;
      end
      oldest_oh[i] = cand[i] && !blocked;
    end
  end

  // Valid entries form a strict age order, so any non-empty candidate set has one winner.
  always @(posedge clk) begin
    if (reset_n && (|cand)) assert ($onehot(oldest_oh));
  end

endmodule

// File: rtl/rs_sched.sv
// rtl/rs_sched.sv - RS allocation pick and oldest-first issue arbitration; RS_SCHED_PERF_EN adds perf counters
module rs_sched
  import rs_sched_pkg::*;
#(
  parameter int NUM_ENTRIES = NUM_RS_ENTRIES,
  parameter int CNT_W       = $clog2(NUM_ENTRIES + 1)
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           disp_valid_rs0,
  output logic                           disp_ready_rs0,
  output logic [NUM_ENTRIES-1:0]         e_alloc_rs0,
  input  logic [NUM_ENTRIES-1:0]         e_valid,
  input  logic [NUM_ENTRIES-1:0]         e_req_issue_rs1,
  input  logic                           ex_ready_rs1,
  output logic [NUM_ENTRIES-1:0]         e_gnt_issue_rs1,
  output logic                           iss_valid_rs1,
  output logic [$clog2(NUM_ENTRIES)-1:0] iss_idx_rs1,
`ifdef RS_SCHED_PERF_EN
  output logic [31:0]                    perf_issue_cnt,
  output logic [31:0]                    perf_full_stall_cnt,
`endif
  output logic [CNT_W-1:0]               occ_rs0
);

  localparam int IDX_W = $clog2(NUM_ENTRIES);

  logic [NUM_ENTRIES-1:0] free_vec;
  logic [NUM_ENTRIES-1:0] alloc_target;
  logic [NUM_ENTRIES-1:0] alloc_oh;
  logic [NUM_ENTRIES-1:0] cand;
  logic [NUM_ENTRIES-1:0] win;
  logic                   alloc_fire;
  logic [CNT_W-1:0]       occ;

  // Allocation: lowest-index free entry, zero-latency. Outputs are held low in reset.
  assign free_vec       = ~e_valid;
  assign alloc_target   = NUM_ENTRIES'(find_first_set(32'(free_vec)));
  assign disp_ready_rs0 = reset_n & (|free_vec);
  assign alloc_fire     = disp_valid_rs0 & disp_ready_rs0;
  assign alloc_oh       = alloc_target & {NUM_ENTRIES{alloc_fire}};
  assign e_alloc_rs0    = alloc_oh;

  // Issue: oldest requesting valid entry; grant only when execute can take it.
  assign cand = e_req_issue_rs1 & e_valid;

  rs_age_matrix #(
    .N(NUM_ENTRIES)
  ) u_age (
    .clk       (clk),
    .reset_n   (reset_n),
    .alloc_oh  (alloc_oh),
    .valid     (e_valid),
    .cand      (cand),
    .oldest_oh (win)
  );

  assign e_gnt_issue_rs1 = win & {NUM_ENTRIES{ex_ready_rs1 & reset_n}};
  assign iss_valid_rs1   = |e_gnt_issue_rs1;
  // The index follows the winner even while execute is stalled.
  assign iss_idx_rs1     = reset_n ? IDX_W'(onehot_to_idx(32'(win))) : '0;

  // Occupancy: +1 on alloc, -1 on grant, unchanged when both happen.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) occ <= '0;
    else if (alloc_fire && !iss_valid_rs1) occ <= occ + CNT_W'(1);
    else if (!alloc_fire && iss_valid_rs1) occ <= occ - CNT_W'(1);
  end

  assign occ_rs0 = occ;

  // Occupancy stays within range and tracks the entries' valid bits.
  always @(posedge clk) begin
    if (reset_n) begin
      assert (occ <= CNT_W'(NUM_ENTRIES));
      assert (!(occ == '0 && iss_valid_rs1));
      assert (int'(occ) == $countones(e_valid));
    end
  end

`ifdef RS_SCHED_PERF_EN
  // Saturating counts of issues and dispatch stalls on a full station.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_issue_cnt      <= '0;
      perf_full_stall_cnt <= '0;
    end else begin
      if (iss_valid_rs1 && perf_issue_cnt != '1)
        perf_issue_cnt <= perf_issue_cnt + 32'd1;
      if (disp_valid_rs0 && !disp_ready_rs0 && perf_full_stall_cnt != '1)
        perf_full_stall_cnt <= perf_full_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rs_sched.sv
// tb/tb_rs_sched.sv - self-checking bench for rs_sched against an age-ordered queue model
module tb_rs_sched;

  localparam int N     = 4;
  localparam int CNT_W = $clog2(N + 1);
  localparam int IDX_W = $clog2(N);

  logic             clk;
  logic             reset_n;
  logic             disp_valid_rs0;
  logic             disp_ready_rs0;
  logic [N-1:0]     e_alloc_rs0;
  logic [N-1:0]     e_valid;
  logic [N-1:0]     e_req_issue_rs1;
  logic             ex_ready_rs1;
  logic [N-1:0]     e_gnt_issue_rs1;
  logic             iss_valid_rs1;
  logic [IDX_W-1:0] iss_idx_rs1;
  logic [CNT_W-1:0] occ_rs0;
`ifdef RS_SCHED_PERF_EN
  logic [31:0]      perf_issue_cnt;
  logic [31:0]      perf_full_stall_cnt;
`endif

  rs_sched #(.NUM_ENTRIES(N)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .disp_valid_rs0  (disp_valid_rs0),
    .disp_ready_rs0  (disp_ready_rs0),
    .e_alloc_rs0     (e_alloc_rs0),
    .e_valid         (e_valid),
    .e_req_issue_rs1 (e_req_issue_rs1),
    .ex_ready_rs1    (ex_ready_rs1),
    .e_gnt_issue_rs1 (e_gnt_issue_rs1),
    .iss_valid_rs1   (iss_valid_rs1),
    .iss_idx_rs1     (iss_idx_rs1),
`ifdef RS_SCHED_PERF_EN
    .perf_issue_cnt      (perf_issue_cnt),
    .perf_full_stall_cnt (perf_full_stall_cnt),
`endif
    .occ_rs0         (occ_rs0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Model: valid entry indices, oldest first.
  int age_q[$];
  int m_issue = 0;
  int m_stall = 0;

  logic [N-1:0] obs_alloc, obs_gnt;
  logic         obs_ready, obs_ivalid;
  logic [IDX_W-1:0] obs_idx;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive at negedge, check combinational and registered outputs, then
  // retire the model at the clock edge (grant leaves the queue, alloc joins as youngest).
  task automatic step(input logic dv, input logic [N-1:0] req, input logic exr);
    logic [N-1:0] valid_m, exp_alloc, exp_gnt;
    int free_idx, win_idx, pos;
    valid_m = '0;
    foreach (age_q[k]) valid_m[age_q[k]] = 1'b1;
    e_valid         = valid_m;
    disp_valid_rs0  = dv;
    e_req_issue_rs1 = req;
    ex_ready_rs1    = exr;
    #1;
    free_idx = -1;
    for (int i = N - 1; i >= 0; i--) if (!valid_m[i]) free_idx = i;
    win_idx = -1;
    for (int k = age_q.size() - 1; k >= 0; k--) if (req[age_q[k]]) win_idx = age_q[k];
    exp_alloc = '0;
    if (dv && free_idx >= 0) exp_alloc = N'(1 << free_idx);
    exp_gnt = '0;
    if (exr && win_idx >= 0) exp_gnt = N'(1 << win_idx);
    obs_alloc = e_alloc_rs0; obs_gnt = e_gnt_issue_rs1; obs_ready = disp_ready_rs0;
    obs_ivalid = iss_valid_rs1; obs_idx = iss_idx_rs1;
    check("disp_ready", 32'(disp_ready_rs0), 32'(free_idx >= 0));
    check("e_alloc", 32'(e_alloc_rs0), 32'(exp_alloc));
    check("e_gnt", 32'(e_gnt_issue_rs1), 32'(exp_gnt));
    check("iss_valid", 32'(iss_valid_rs1), 32'(exp_gnt != '0));
    check("iss_idx", 32'(iss_idx_rs1), (win_idx >= 0) ? 32'(win_idx) : 32'd0);
    check("occ", 32'(occ_rs0), 32'(age_q.size()));
`ifdef RS_SCHED_PERF_EN
    check("perf_issue", perf_issue_cnt, 32'(m_issue));
    check("perf_stall", perf_full_stall_cnt, 32'(m_stall));
`endif
    @(posedge clk);
    if (exp_gnt != '0) begin
      pos = -1;
      foreach (age_q[k]) if (age_q[k] == win_idx) pos = k;
      if (pos >= 0) age_q.delete(pos);
      m_issue++;
    end
    if (exp_alloc != '0) age_q.push_back(free_idx);
    if (dv && free_idx < 0) m_stall++;
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < N + 1; i++) step(1'b0, '1, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; disp_valid_rs0 = 1'b1; e_valid = '0;
    e_req_issue_rs1 = '0; ex_ready_rs1 = 1'b1;
    #2;
    check("rst_ready", 32'(disp_ready_rs0), 32'd0);
    check("rst_alloc", 32'(e_alloc_rs0), 32'd0);
    check("rst_occ", 32'(occ_rs0), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Four back-to-back dispatches fill the station in index order.
    for (int i = 0; i < N; i++) begin
      step(1'b1, '0, 1'b0);
      check("fill_alloc", 32'(obs_alloc), 32'(1 << i));
    end
    step(1'b1, '0, 1'b0);
    check("full_ready", 32'(obs_ready), 32'd0);
    check("full_occ", 32'(occ_rs0), 32'd4);
    drain();

    // Build allocation order 2,0,3 and issue everything in that order.
    step(1'b1, '0, 1'b0);
    step(1'b1, '0, 1'b0);
    step(1'b1, 4'b0001, 1'b1);
    step(1'b1, '0, 1'b0);
    step(1'b1, '0, 1'b0);
    step(1'b0, 4'b0010, 1'b1);
    step(1'b0, 4'b1111, 1'b1); check("age_g0", 32'(obs_gnt), 32'b0100);
    step(1'b0, 4'b1111, 1'b1); check("age_g1", 32'(obs_gnt), 32'b0001);
    step(1'b0, 4'b1111, 1'b1); check("age_g2", 32'(obs_gnt), 32'b1000);

    // Full station: grant entry 1 while dispatch is held; ready returns next cycle.
    for (int i = 0; i < N; i++) step(1'b1, '0, 1'b0);
    step(1'b1, 4'b0010, 1'b1);
    check("fg_ready_t", 32'(obs_ready), 32'd0);
    step(1'b1, '0, 1'b0);
    check("fg_ready_t1", 32'(obs_ready), 32'd1);
    check("fg_alloc_t1", 32'(obs_alloc), 32'b0010);
    step(1'b0, '0, 1'b0);
    check("fg_occ", 32'(occ_rs0), 32'd4);
    drain();

    // Stall execute with entries 3 (older) and 0 requesting.
    for (int i = 0; i < N; i++) step(1'b1, '0, 1'b0);
    step(1'b0, 4'b0001, 1'b1);
    step(1'b1, '0, 1'b0);
    step(1'b0, 4'b0010, 1'b1);
    step(1'b0, 4'b0100, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 4'b1001, 1'b0);
      check("stall_ivalid", 32'(obs_ivalid), 32'd0);
    end
    step(1'b0, 4'b1001, 1'b1);
    check("rel_gnt", 32'(obs_gnt), 32'b1000);
    check("rel_idx", 32'(obs_idx), 32'd3);

    // Alloc into 2 while granting 0: occupancy holds, and 1 outranks the new 2.
    step(1'b1, '0, 1'b0);
    step(1'b1, 4'b0001, 1'b1);
    check("sim_alloc", 32'(obs_alloc), 32'b0100);
    step(1'b0, 4'b0110, 1'b1);
    check("sim_gnt", 32'(obs_gnt), 32'b0010);

    // Mid-cycle reset with three entries occupied.
    step(1'b1, '0, 1'b0);
    step(1'b1, '0, 1'b0);
    check("pre_rst_occ", 32'(occ_rs0), 32'd3);
    disp_valid_rs0 = 1'b1; e_req_issue_rs1 = '1; ex_ready_rs1 = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    check("mrst_ready", 32'(disp_ready_rs0), 32'd0);
    check("mrst_alloc", 32'(e_alloc_rs0), 32'd0);
    check("mrst_gnt", 32'(e_gnt_issue_rs1), 32'd0);
    check("mrst_ivalid", 32'(iss_valid_rs1), 32'd0);
    check("mrst_idx", 32'(iss_idx_rs1), 32'd0);
    check("mrst_occ", 32'(occ_rs0), 32'd0);
    age_q.delete();
    m_issue = 0;
    m_stall = 0;
    @(negedge clk);
    e_valid = '0;
    reset_n = 1'b1;
    step(1'b0, '0, 1'b0);
    check("post_rst_ready", 32'(obs_ready), 32'd1);

    // Random traffic against the model.
    for (int c = 0; c < 400; c++) begin
      step(1'($urandom_range(0, 1)), N'($urandom), ($urandom_range(0, 3) != 0));
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
